// File: rtl/sevenseg_mux_n.sv
// sevenseg_mux_n: multiplexed common-anode seven-segment driver, hex or double-dabble decimal.
// Define SEVENSEG_LZB_EN to blank leading zeros on every display-register update.
module sevenseg_mux_n #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  dec_mode,
    input  logic [DIGITS-1:0]     dp_in,
    output logic                  busy,
    output logic                  ovf,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);
    localparam int NW = 4 * DIGITS;
    localparam int BW = 4 * (DIGITS + 2);
    localparam int CW = $clog2(NW);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NW-1:0]     shift_q, shift_d, shift_nx;
    logic [BW-1:0]     bcd_q, bcd_d, bcd_adj, bcd_nx;
    logic [NW-1:0]     disp_q, disp_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              ovf_q, ovf_d, upd;
    logic [RW-1:0]     refresh_cnt_q, refresh_cnt_d;
    logic [SW-1:0]     digit_sel_q, digit_sel_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              dp_q, dp_d, wrap;
    logic [3:0]        nib;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

`ifdef SEVENSEG_LZB_EN
    // Digit i blanks when it and every digit above it are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lzb(input logic [NW-1:0] v);
        logic z;
        z = 1'b1;
        lzb = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z = z & (v[4*i +: 4] == 4'd0);
            lzb[i] = z;
        end
    endfunction
`endif

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS + 2; i++)
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        {bcd_nx, shift_nx} = {bcd_adj, shift_q} << 1;
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        upd     = 1'b0;
        if (state_q == IDLE) begin
            if (load && !dec_mode) begin
                disp_d = value;
                ovf_d  = 1'b0;
                upd    = 1'b1;
            end else if (load) begin
                shift_d = value;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = CONV;
            end
        end else begin
            shift_d = shift_nx;
            bcd_d   = bcd_nx;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(NW - 1)) begin
                state_d = IDLE;
                disp_d  = bcd_nx[NW-1:0];
                ovf_d   = |bcd_nx[BW-1:NW];
                upd     = 1'b1;
            end
        end
`ifdef SEVENSEG_LZB_EN
        blank_d = upd ? (ovf_d ? '0 : lzb(disp_d)) : blank_q;
`else
        blank_d = '0;
`endif
    end

    // Outputs are computed from the registered digit select so seg/an/dp switch together.
    always_comb begin
        wrap          = refresh_cnt_q == RW'(REFRESH_DIV - 1);
        refresh_cnt_d = wrap ? '0 : refresh_cnt_q + 1'b1;
        digit_sel_d   = !wrap ? digit_sel_q : (digit_sel_q == SW'(DIGITS - 1)) ? '0 : digit_sel_q + 1'b1;
        nib           = disp_q[4*int'(digit_sel_q) +: 4];
        seg_d         = ovf_q ? 7'b0111111 : blank_q[digit_sel_q] ? 7'b1111111 : glyph(nib);
        an_d          = ~(DIGITS'(1) << digit_sel_q);
        dp_d          = ~dp_in[digit_sel_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            bcd_q         <= '0;
            disp_q        <= '0;
            blank_q       <= '0;
            ovf_q         <= 1'b0;
            refresh_cnt_q <= '0;
            digit_sel_q   <= '0;
            seg_q         <= 7'b1000000;
            an_q          <= ~DIGITS'(1);
            dp_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            bcd_q         <= bcd_d;
            disp_q        <= disp_d;
            blank_q       <= blank_d;
            ovf_q         <= ovf_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_sel_q   <= digit_sel_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
        end
    end

    assign busy = state_q == CONV;
    assign ovf  = ovf_q;
    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = dp_q;
endmodule

// File: tb/tb_sevenseg_mux_n.sv
// tb_sevenseg_mux_n: vector table plus scoreboard of per-digit {an, seg, dp} for sevenseg_mux_n.
module tb_sevenseg_mux_n;
    localparam int D = 4;
    localparam int R = 4;

    logic         clk = 1'b0, reset = 1'b1, load = 1'b0, dec_mode = 1'b0;
    logic [15:0]  value = '0;
    logic [3:0]   dp_in = '0;
    logic         busy, ovf, dp;
    logic [6:0]   seg;
    logic [3:0]   an;
    int           n_cmp = 0, n_bad = 0;

    typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; } exp_t;
    typedef struct { logic [15:0] value; logic dec; logic [3:0] dpv; logic [15:0] digits; logic ovf; } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    sevenseg_mux_n #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .dec_mode(dec_mode),
        .dp_in(dp_in), .busy(busy), .ovf(ovf), .seg(seg), .an(an), .dp(dp)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] digits, input logic o, input logic [3:0] dpv);
        logic       z;
        logic [3:0] blk;
        exp_t       e;
        z = 1'b1;
        blk = '0;
        for (int d = D - 1; d > 0; d--) begin
            z = z && (digits[4*d +: 4] == 4'd0);
            blk[d] = z;
        end
`ifndef SEVENSEG_LZB_EN
        blk = '0;
`endif
        for (int d = 0; d < D; d++) begin
            e.an  = ~(4'b0001 << d);
            e.seg = o ? 7'b0111111 : blk[d] ? 7'b1111111 : glyph(digits[4*d +: 4]);
            e.dp  = ~dpv[d];
            sb.push_back(e);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic dm);
        value = v;
        dec_mode = dm;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for a fresh digit-0 slot, then checks one full scan against the scoreboard.
    task automatic check_scan(input string name);
        exp_t       e;
        logic [3:0] prev;
        int         t;
        prev = an;
        @(negedge clk);
        t = 1;
        while (!(an == 4'b1110 && prev != 4'b1110) && t < 64) begin
            prev = an;
            @(negedge clk);
            t++;
        end
        chk({name, " scan_start"}, 32'(t < 64), 32'd1);
        for (int d = 0; d < D; d++) begin
            e = sb.pop_front();
            chk($sformatf("%s digit%0d", name, d), {an, seg, dp}, {e.an, e.seg, e.dp});
            repeat (R) @(negedge clk);
        end
    endtask

    initial begin
        int         n, hold;
        logic [3:0] prev;
        vecs[0] = '{16'hBEEF, 1'b0, 4'b0000, 16'hBEEF, 1'b0};
        vecs[1] = '{16'd1234, 1'b1, 4'b0001, 16'h1234, 1'b0};
        vecs[2] = '{16'd10000, 1'b1, 4'b1010, 16'h0000, 1'b1};
        vecs[3] = '{16'h0001, 1'b0, 4'b0000, 16'h0001, 1'b0};
        vecs[4] = '{16'd0, 1'b1, 4'b0100, 16'h0000, 1'b0};
        vecs[5] = '{16'd9999, 1'b1, 4'b1000, 16'h9999, 1'b0};
        vecs[6] = '{16'hFFFF, 1'b1, 4'b0000, 16'h0000, 1'b1};
        vecs[7] = '{16'h00A0, 1'b0, 4'b1111, 16'h00A0, 1'b0};
        vecs[8] = '{16'd3840, 1'b1, 4'b0011, 16'h3840, 1'b0};
        vecs[9] = '{16'd10, 1'b1, 4'b0000, 16'h0010, 1'b0};

        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset ovf", ovf, 0);
        chk("reset an", an, 4'b1110);
        chk("reset seg", seg, 7'b1000000);
        chk("reset dp", dp, 1);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            dp_in = vecs[i].dpv;
            push_exp(vecs[i].digits, vecs[i].ovf, vecs[i].dpv);
            do_load(vecs[i].value, vecs[i].dec);
            count_busy(n);
            chk($sformatf("vec%0d busy_cycles", i), n, vecs[i].dec ? 16 : 0);
            chk($sformatf("vec%0d ovf", i), ovf, vecs[i].ovf);
            check_scan($sformatf("vec%0d", i));
        end

        prev = an;
        @(negedge clk);
        n = 1;
        while (!(an == 4'b1110 && prev != 4'b1110) && n < 64) begin
            prev = an;
            @(negedge clk);
            n++;
        end
        hold = 0;
        while (an == 4'b1110 && hold < 20) begin
            @(negedge clk);
            hold++;
        end
        chk("slot_len", hold, R);
        chk("next_digit an", an, 4'b1101);

        dp_in = 4'b0000;
        push_exp(16'h0099, 1'b0, 4'b0000);
        do_load(16'd99, 1'b1);
        repeat (2) @(negedge clk);
        do_load(16'h1234, 1'b0);
        chk("busy_load busy", busy, 1);
        count_busy(n);
        chk("busy_load remaining", n, 13);
        chk("busy_load ovf", ovf, 0);
        check_scan("busy_load");

        dp_in = 4'b1111;
        do_load(16'd1234, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset ovf", ovf, 0);
        chk("midreset an", an, 4'b1110);
        chk("midreset seg", seg, 7'b1000000);
        chk("midreset dp", dp, 1);
        @(negedge clk);
        reset = 1'b0;
        dp_in = 4'b0000;
        repeat (4) @(negedge clk);
        chk("postreset an0", an, 4'b1110);
        @(negedge clk);
        chk("postreset an1", an, 4'b1101);
        chk("postreset seg1", seg, 7'b1000000);
        chk("postreset busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
